// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA raster timing generator.
// Defaults describe 800x600@60; the counter width bounds any timing set.
package vga_pkg;

    localparam int CNT_W     = 11;
    localparam int MAX_TOTAL = 1 << CNT_W;

    localparam int DEF_H_VISIBLE = 800;
    localparam int DEF_H_FRONT   = 40;
    localparam int DEF_H_SYNC    = 128;
    localparam int DEF_H_BACK    = 88;
    localparam int DEF_V_VISIBLE = 600;
    localparam int DEF_V_FRONT   = 1;
    localparam int DEF_V_SYNC    = 4;
    localparam int DEF_V_BACK    = 23;

    localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    typedef enum logic [1:0] {
        ACT  = 2'd0,
        FP   = 2'd1,
        SYNC = 2'd2,
        BP   = 2'd3
    } phase_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter, blanking phase FSM and a
// registered sync flag (active-high; the top applies the output polarity).
module vga_axis_counter #(
    parameter int VISIBLE = vga_pkg::DEF_H_VISIBLE,
    parameter int FRONT   = vga_pkg::DEF_H_FRONT,
    parameter int SYNC    = vga_pkg::DEF_H_SYNC,
    parameter int BACK    = vga_pkg::DEF_H_BACK
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_step,
    output logic [vga_pkg::CNT_W-1:0]  o_count,
    output vga_pkg::phase_t            o_phase,
    output logic                       o_sync,
    output logic                       o_wrap
);
    import vga_pkg::*;

    localparam int TOTAL = VISIBLE + FRONT + SYNC + BACK;

    localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] FP_START   = CNT_W'(VISIBLE);
    localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(VISIBLE + FRONT);
    localparam logic [CNT_W-1:0] BP_START   = CNT_W'(VISIBLE + FRONT + SYNC);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    phase_t           r_phase;
    phase_t           w_phase_next;
    logic             r_sync;

    // Terminal count: the next step returns this axis to zero.
    assign o_wrap = (r_count == LAST);

    always_comb begin
        // NOTE: hold-by-default assignments keep this block free of inferred latches.
        w_count_next = r_count;
        w_phase_next = r_phase;
        if (i_step) begin
            w_count_next = o_wrap ? '0 : r_count + 1'b1;
            case (r_phase)
                ACT:           if (w_count_next == FP_START)   w_phase_next = FP;
                FP:            if (w_count_next == SYNC_START) w_phase_next = vga_pkg::SYNC;
                vga_pkg::SYNC: if (w_count_next == BP_START)   w_phase_next = BP;
                BP:            if (w_count_next == '0)         w_phase_next = ACT;
                default:       w_phase_next = BP;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= LAST;
            r_phase <= BP;
            r_sync  <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_phase <= w_phase_next;
            r_sync  <= (w_phase_next == vga_pkg::SYNC);
        end
    end

    assign o_count = r_count;
    assign o_phase = r_phase;
    assign o_sync  = r_sync;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: packed pixel address, syncs, blanking and line/frame
// markers, all aligned to the held position. Optional: VGA_FRAME_CNT_EN adds frame_cnt.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_VISIBLE = DEF_H_VISIBLE,
    parameter int   H_FRONT   = DEF_H_FRONT,
    parameter int   H_SYNC    = DEF_H_SYNC,
    parameter int   H_BACK    = DEF_H_BACK,
    parameter int   V_VISIBLE = DEF_V_VISIBLE,
    parameter int   V_FRONT   = DEF_V_FRONT,
    parameter int   V_SYNC    = DEF_V_SYNC,
    parameter int   V_BACK    = DEF_V_BACK,
    parameter logic SYNC_POL  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pix_en,
    output logic [2*CNT_W-1:0]   display_addr,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 active,
    output logic                 line_start,
`ifdef VGA_FRAME_CNT_EN
    output logic [15:0]          frame_cnt,
`endif
    output logic                 frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_timing
        $fatal(1, "vga_timing_gen: H_TOTAL or V_TOTAL exceeds the 11-bit counter range");
    end

    logic [CNT_W-1:0] w_h_count;
    logic [CNT_W-1:0] w_v_count;
    phase_t           w_h_phase;
    phase_t           w_v_phase;
    logic             w_h_sync;
    logic             w_v_sync;
    logic             w_h_wrap;
    logic             w_v_wrap;
    logic             w_v_step;

    logic r_line_start;
    logic r_frame_start;

    // The vertical axis moves only on the pixel edge that ends a line.
    assign w_v_step = w_h_wrap & pix_en;

    vga_axis_counter #(
        .VISIBLE (H_VISIBLE),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK)
    ) u_h_axis (
        .clk     (clk),
        .rst     (rst),
        .i_step  (pix_en),
        .o_count (w_h_count),
        .o_phase (w_h_phase),
        .o_sync  (w_h_sync),
        .o_wrap  (w_h_wrap)
    );

    vga_axis_counter #(
        .VISIBLE (V_VISIBLE),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK)
    ) u_v_axis (
        .clk     (clk),
        .rst     (rst),
        .i_step  (w_v_step),
        .o_count (w_v_count),
        .o_phase (w_v_phase),
        .o_sync  (w_v_sync),
        .o_wrap  (w_v_wrap)
    );

    // Markers are loaded with the step that enters x == 0 / (0,0), so they
    // describe the position being entered, in step with the counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (pix_en) begin
            r_line_start  <= w_h_wrap;
            r_frame_start <= w_h_wrap & w_v_wrap;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= '0;
        end else if (pix_en && w_h_wrap && w_v_wrap) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

    assign display_addr = {w_h_count, w_v_count};
    assign hsync        = SYNC_POL ? w_h_sync : ~w_h_sync;
    assign vsync        = SYNC_POL ? w_v_sync : ~w_v_sync;
    assign active       = (w_h_phase == ACT) && (w_v_phase == ACT);
    assign line_start   = r_line_start;
    assign frame_start  = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a default 800x600 instance and a shrunken, negative-polarity
// instance share stimulus; a position-level reference model predicts both.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst;
    logic pix_en;

    logic [21:0] addr0, addr1;
    logic        hs0, vs0, act0, ls0, fs0;
    logic        hs1, vs1, act1, ls1, fs1;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] fc0, fc1;
`endif

    int   hv  [2] = '{800, 16};
    int   hf  [2] = '{40,  4};
    int   hsw [2] = '{128, 6};
    int   hb  [2] = '{88,  5};
    int   vv  [2] = '{600, 10};
    int   vf  [2] = '{1,   1};
    int   vsw [2] = '{4,   2};
    int   vb  [2] = '{23,  3};
    logic pol [2] = '{1'b1, 1'b0};

    typedef struct packed {
        logic [21:0] addr;
        logic        hs;
        logic        vs;
        logic        act;
        logic        ls;
        logic        fs;
        logic [15:0] fc;
    } obs_t;

    obs_t sb0 [$];
    obs_t sb1 [$];

    int mx  [2];
    int my  [2];
    int mfc [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    vga_timing_gen dut_def (
        .clk          (clk),
        .rst          (rst),
        .pix_en       (pix_en),
        .display_addr (addr0),
        .hsync        (hs0),
        .vsync        (vs0),
        .active       (act0),
        .line_start   (ls0),
`ifdef VGA_FRAME_CNT_EN
        .frame_cnt    (fc0),
`endif
        .frame_start  (fs0)
    );

    vga_timing_gen #(
        .H_VISIBLE (16), .H_FRONT (4), .H_SYNC (6), .H_BACK (5),
        .V_VISIBLE (10), .V_FRONT (1), .V_SYNC (2), .V_BACK (3),
        .SYNC_POL  (1'b0)
    ) dut_small (
        .clk          (clk),
        .rst          (rst),
        .pix_en       (pix_en),
        .display_addr (addr1),
        .hsync        (hs1),
        .vsync        (vs1),
        .active       (act1),
        .line_start   (ls1),
`ifdef VGA_FRAME_CNT_EN
        .frame_cnt    (fc1),
`endif
        .frame_start  (fs1)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    function automatic int h_total(int k);
        return hv[k] + hf[k] + hsw[k] + hb[k];
    endfunction

    function automatic int v_total(int k);
        return vv[k] + vf[k] + vsw[k] + vb[k];
    endfunction

    // Expected outputs follow directly from the position held by the model.
    function automatic obs_t expect_obs(int k);
        obs_t        o;
        logic [31:0] xv;
        logic [31:0] yv;
        logic [31:0] fv;
        xv     = mx[k];
        yv     = my[k];
        fv     = mfc[k];
        o.addr = {xv[10:0], yv[10:0]};
        o.hs   = (mx[k] >= hv[k] + hf[k] && mx[k] < hv[k] + hf[k] + hsw[k]) ? pol[k] : !pol[k];
        o.vs   = (my[k] >= vv[k] + vf[k] && my[k] < vv[k] + vf[k] + vsw[k]) ? pol[k] : !pol[k];
        o.act  = (mx[k] < hv[k]) && (my[k] < vv[k]);
        o.ls   = (mx[k] == 0);
        o.fs   = (mx[k] == 0) && (my[k] == 0);
`ifdef VGA_FRAME_CNT_EN
        o.fc   = fv[15:0];
`else
        o.fc   = 16'd0;
`endif
        return o;
    endfunction

    function automatic obs_t observed(int k);
        obs_t o;
        if (k == 0) begin
            o = {addr0, hs0, vs0, act0, ls0, fs0, 16'd0};
`ifdef VGA_FRAME_CNT_EN
            o.fc = fc0;
`endif
        end else begin
            o = {addr1, hs1, vs1, act1, ls1, fs1, 16'd0};
`ifdef VGA_FRAME_CNT_EN
            o.fc = fc1;
`endif
        end
        return o;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mx[k]  = h_total(k) - 1;
            my[k]  = v_total(k) - 1;
            mfc[k] = 0;
        end
    endtask

    task automatic model_step(input logic pe);
        if (pe) begin
            for (int k = 0; k < 2; k++) begin
                if (mx[k] == h_total(k) - 1) begin
                    mx[k] = 0;
                    my[k] = (my[k] == v_total(k) - 1) ? 0 : my[k] + 1;
                end else begin
                    mx[k] = mx[k] + 1;
                end
                if (mx[k] == 0 && my[k] == 0) mfc[k] = (mfc[k] + 1) % 65536;
            end
        end
    endtask

    task automatic push_expected();
        sb0.push_back(expect_obs(0));
        sb1.push_back(expect_obs(1));
    endtask

    task automatic step(input logic pe);
        #1 pix_en = pe;
        @(posedge clk);
        model_step(pe);
        push_expected();
    endtask

    // Asserts reset just after a monitor sample, checks the asynchronous
    // response before any clock edge, then holds reset for n edges.
    task automatic reset_pulse(input int n);
        @(negedge clk);
        #1 rst = 1'b1;
        model_reset();
        #1;
        check("rst_async_def", 64'(observed(0)), 64'(expect_obs(0)));
        check("rst_async_small", 64'(observed(1)), 64'(expect_obs(1)));
        check("rst_addr_def", 64'(addr0), 64'({11'd1055, 11'd627}));
        pix_en = 1'b1;
        repeat (n) begin
            @(posedge clk);
            push_expected();
        end
        #1 rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (sb0.size() > 0) begin
            obs_t e;
            e = sb0.pop_front();
            check($sformatf("dut_def@%0t", $time), 64'(observed(0)), 64'(e));
        end
        if (sb1.size() > 0) begin
            obs_t e;
            e = sb1.pop_front();
            check($sformatf("dut_small@%0t", $time), 64'(observed(1)), 64'(e));
        end
    end

    initial begin
        rst    = 1'b1;
        pix_en = 1'b0;
        reset_pulse(3);

        repeat (10) step(1'b0);
        repeat (2200) step(1'b1);
        for (int i = 0; i < 3000; i++) step(i % 2 == 0);
        for (int i = 0; i < 20000; i++) step($urandom_range(0, 3) != 0);

        begin
            int guard;
            guard = 0;
            while (mx[0] != 400 && guard < 2000) begin
                step(1'b1);
                guard++;
            end
        end
        reset_pulse(2);
        repeat (1200) step(1'b1);
        for (int i = 0; i < 2000; i++) step($urandom_range(0, 1) != 0);

        @(negedge clk);
        #1;
        check("scoreboard_drained", 64'(sb0.size() + sb1.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the 800x600@60 display path. Sweeps the horizontal and vertical pixel counters and produces the packed `display_addr` consumed by the image pixel mapper. Also drives the monitor `hsync`/`vsync` and the blanking and frame markers used by the colour output stage. It sits directly upstream of the mapper, and all of its outputs are mutually aligned registers.

## Interface
- `H_VISIBLE`, 800, visible pixels per line
- `H_FRONT`, 40, horizontal front porch, in pixels
- `H_SYNC`, 128, hsync pulse width, in pixels
- `H_BACK`, 88, horizontal back porch, in pixels
- `V_VISIBLE`, 600, visible lines per frame
- `V_FRONT`, 1, vertical front porch, in lines
- `V_SYNC`, 4, vsync pulse width, in lines
- `V_BACK`, 23, vertical back porch, in lines
- `SYNC_POL`, 1, asserted level of `hsync`/`vsync`
- `clk` in 1: single clock; reset is asynchronous and active-high
- `rst` in 1: asynchronous, active-high reset
- `pix_en` in 1: pixel-rate enable; the position advances only on edges where this is 1
- `display_addr` out 22: {x[10:0], y[10:0]}, the raw counter values at all times, including blanking
- `hsync` out 1: horizontal sync, at `SYNC_POL` level when asserted
- `vsync` out 1: vertical sync, at `SYNC_POL` level when asserted
- `active` out 1: 1 when x < `H_VISIBLE` and y < `V_VISIBLE`
- `line_start` out 1: 1 while x == 0
- `frame_start` out 1: 1 while x == 0 and y == 0

## Operation
- Derived totals: H_TOTAL = sum of the four H_* parameters = 1056; V_TOTAL = 628.
- Elaboration check: H_TOTAL and V_TOTAL must each be ≤ 2048; a violation is a fatal error.
- Horizontal phase FSM, H_ACT → H_FP → H_SYNC → H_BP → H_ACT:
  - Transitions occur on the pix_en edge at which x enters 800, 840, 968 and 0 respectively.
- Vertical phase FSM, V_ACT → V_FP → V_SYNC → V_BP → V_ACT:
  - Same structure as horizontal, at y = 600, 601, 605, 0.
  - It advances only on the edge where x wraps.
- Counter stepping on each edge with pix_en=1:
  - x = (x == H_TOTAL−1) ? 0 : x+1.
  - On the x wrap: y = (y == V_TOTAL−1) ? 0 : y+1.
- `hsync` is asserted exactly while in H_SYNC (x 840..967).
- `vsync` is asserted exactly while in V_SYNC (y 601..604).
- Simultaneous x and y wrap, (1055,627) → (0,0): both FSMs land in their ACT state on that edge, `frame_start` rises, `line_start` rises.
- pix_en=0 on an edge: every register holds, and all outputs stay stable.
- Outputs are registered alongside the counters. They describe the position currently held, never the next one.

## Timing
- Reset (async assert) values:
  - x = H_TOTAL−1, y = V_TOTAL−1; phases H_BP/V_BP.
  - `display_addr` = {11'd1055, 11'd627}.
  - `hsync`/`vsync` = !SYNC_POL.
  - `active`, `line_start`, `frame_start` = 0.
- First pix_en edge after reset release: position (0,0), `active`=1, `line_start`=1, `frame_start`=1.
- Latency: zero cycles from a position change to its outputs; every output changes on the same edge.
- Reset asserted mid-frame: outputs return to their reset values immediately (asynchronous); no partial sync pulse is extended.
- Cadence with pix_en tied high:
  - one line every 1056 clocks;
  - one frame every 663168 clocks;
  - `frame_start` high for exactly 1 clock per frame.

## Configuration
- `VGA_FRAME_CNT_EN` defined:
  - Adds output port `frame_cnt` (out, 16 bits), reset value 0.
  - Increments on every edge that enters (0,0); wraps 65535 → 0.
- Not defined: the port and its register are absent; all other behaviour is identical.

## Structure
- Package `vga_pkg`:
  - Default timing constants and the derived totals.
  - Counter width constant (11).
  - `phase_t` enum: ACT, FP, SYNC, BP.
- Sub-module `vga_axis_counter`, instantiated twice (horizontal and vertical):
  - Parameters: VISIBLE, FRONT, SYNC, BACK.
  - Inputs: step enable.
  - Outputs: count, phase, sync, wrap pulse.
  - Wiring: the vertical step enable is the horizontal wrap ANDed with pix_en.

## Test plan
- Reset, then release with pix_en=0 for 10 cycles → `display_addr` = {1055,627}, syncs at !SYNC_POL, `active`=0 throughout.
- pix_en=1 from release → (0,0) with `frame_start`=1; at clock 800 `active` falls; `hsync` is asserted on clocks 840–967 and deasserts at x=968.
- Run through line end → (1055,0) is followed by (0,1) with `line_start`=1; `vsync` is asserted only on lines 601–604.
- pix_en toggled 1/0 every cycle → the position advances every other clock; a full frame takes 1326336 clocks.
- Assert `rst` at (400,300) → outputs return to reset values the same cycle; after release the next frame starts cleanly at (0,0).
- With `VGA_FRAME_CNT_EN`, force `frame_cnt`=65535 and run to the frame end → it reads 0 at (0,0); without the macro the port does not elaborate.
